// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state type, field polynomial and GF(2^8) helpers
// used by both the MixColumns and InvMixColumns datapaths.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] AES_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply by a 4-bit constant; every coefficient we need fits.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] gf_x2(input logic [7:0] a);
    return xtime(a);
  endfunction

  function automatic logic [7:0] gf_x9(input logic [7:0] a);
    return gf_mul(a, 4'd9);
  endfunction

  function automatic logic [7:0] gf_x11(input logic [7:0] a);
    return gf_mul(a, 4'd11);
  endfunction

  function automatic logic [7:0] gf_x13(input logic [7:0] a);
    return gf_mul(a, 4'd13);
  endfunction

  function automatic logic [7:0] gf_x14(input logic [7:0] a);
    return gf_mul(a, 4'd14);
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumn of one 32-bit column; byte 0 is the column MSB.
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign col_o[31:24] = gf_x14(a0) ^ gf_x11(a1) ^ gf_x13(a2) ^ gf_x9(a3);
  assign col_o[23:16] = gf_x9(a0)  ^ gf_x14(a1) ^ gf_x11(a2) ^ gf_x13(a3);
  assign col_o[15:8]  = gf_x13(a0) ^ gf_x9(a1)  ^ gf_x14(a2) ^ gf_x11(a3);
  assign col_o[7:0]   = gf_x11(a0) ^ gf_x13(a1) ^ gf_x9(a2)  ^ gf_x14(a3);

endmodule

// File: rtl/inv_mix_columns.sv
// Iterative InvMixColumns over a 128-bit AES state: one column per clock
// through a single shared column transformer.
module inv_mix_columns
  import aes_pkg::*;
#(
  parameter int NCOLS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] LAST_COL = 2'(NCOLS - 1);

  state_e           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [3:0][31:0] data_q, data_d;
  logic [31:0]      colIn, colOut;

  // Column c lives at packed index 3-c so column 0 sits in the top 32 bits.
  assign colIn = data_q[2'd3 - col_q];

  inv_mix_column u_col (
    .col_i (colIn),
    .col_o (colOut)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = BUSY;
          col_d   = 2'd0;
          data_d  = data_in;
        end
      end
      BUSY: begin
        data_d[2'd3 - col_q] = colOut;
        col_d                = col_q + 2'd1;
        if (col_q == LAST_COL) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign data_out = data_q;
  assign busy     = (state_q == BUSY);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_inv_mix_columns.sv
// Randomised self-checking bench for inv_mix_columns against a GF(2^8) matrix
// model, with directed latency, restart, abort and round-trip scenarios.
module tb_inv_mix_columns;

  localparam logic [127:0] VEC_IN  = 128'h8e4da1bc9fdc589d01010101d5d5d7d6;
  localparam logic [127:0] VEC_OUT = 128'hdb135345f20a225c01010101d4d4d4d5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] data_out;
  logic         busy;
  logic         done;

  int total = 0;
  int bad = 0;

  // Reference timeline: 0 idle, 1..4 busy cycles, 5 done cycle.
  int           mPhase = 0;
  logic [127:0] mExp = '0;

  inv_mix_columns #(.NCOLS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix product applied to every column; inverse selects InvMixColumns.
  function automatic logic [127:0] colXform(input logic [127:0] s, input bit inverse);
    int          coef [4];
    logic [127:0] r;
    logic [7:0]  acc;
    r = '0;
    if (inverse) coef = '{14, 11, 13, 9};
    else         coef = '{2, 3, 1, 1};
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int i = 0; i < 4; i++)
          acc = acc ^ gmul(s[127 - 32*c - 8*i -: 8], coef[(i - row + 4) % 4]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [129:0] act, input logic [129:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) mPhase = 0;
    else if (mPhase == 0) begin
      if (enable) begin
        mPhase = 1;
        mExp   = colXform(data_in, 1'b1);
      end
    end else if (mPhase == 5) mPhase = 0;
    else mPhase = mPhase + 1;
  end

  always @(negedge clk) begin
    if (reset)
      checkOutput("reset_outputs", {busy, done, data_out}, 130'd0);
    else begin
      checkOutput("busy_done", {128'd0, busy, done},
                  {128'd0, (mPhase >= 1 && mPhase <= 4), (mPhase == 5)});
      if (mPhase == 5) checkOutput("model_result", {2'b00, data_out}, {2'b00, mExp});
    end
  end

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Start one operation, scramble data_in after capture, then measure latency.
  task automatic applyStimulus(input logic [127:0] din, input logic [127:0] want, input string name);
    int edges;
    @(negedge clk);
    data_in = din;
    enable  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable  = 1'b0;
    data_in = rand128();
    edges = 0;
    while (!done && edges < 10) begin
      @(negedge clk);
      edges++;
    end
    checkOutput({name, "_latency"}, 130'(edges), 130'd4);
    checkOutput({name, "_data"}, {2'b00, data_out}, {2'b00, want});
    @(negedge clk);
  endtask

  initial begin
    int doneCnt;
    int lastDone;
    logic [127:0] x;

    checkOutput("pin_inv_vec", {2'b00, colXform(VEC_IN, 1'b1)}, {2'b00, VEC_OUT});
    checkOutput("pin_mix_vec", {2'b00, colXform(VEC_OUT, 1'b0)}, {2'b00, VEC_IN});
    checkOutput("pin_inv_ones", {2'b00, colXform({128{1'b1}}, 1'b1)}, {2'b00, {128{1'b1}}});

    repeat (2) @(negedge clk);
    checkOutput("reset_state", {busy, done, data_out}, 130'd0);

    // Enable arrives together with the first edge after reset release.
    data_in = VEC_IN;
    enable  = 1'b1;
    reset   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("first_edge_enable", {1'b0, done, data_out}, {1'b0, 1'b1, VEC_OUT});
    @(negedge clk);

    applyStimulus(VEC_IN, VEC_OUT, "vector");
    applyStimulus(128'd0, 128'd0, "zeros");
    applyStimulus({128{1'b1}}, {128{1'b1}}, "ones");

    // Enable re-pulsed during BUSY with other data must be ignored.
    @(negedge clk);
    data_in = VEC_IN;
    enable  = 1'b1;
    @(negedge clk);
    enable  = 1'b0;
    @(negedge clk);
    data_in = rand128();
    enable  = 1'b1;
    @(negedge clk);
    enable  = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        doneCnt++;
        checkOutput("busy_repulse_data", {2'b00, data_out}, {2'b00, VEC_OUT});
      end
      @(negedge clk);
    end
    checkOutput("busy_repulse_count", 130'(doneCnt), 130'd1);

    // Enable held high: a new operation every 6 cycles.
    data_in  = VEC_IN;
    enable   = 1'b1;
    doneCnt  = 0;
    lastDone = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        if (lastDone >= 0) checkOutput("held_spacing", 130'(i - lastDone), 130'd6);
        else               checkOutput("held_first", 130'(i), 130'd4);
        lastDone = i;
        doneCnt++;
      end
    end
    enable = 1'b0;
    checkOutput("held_count", 130'(doneCnt), 130'd3);
    repeat (6) @(negedge clk);

    // Asynchronous reset in the second BUSY cycle aborts without a done pulse.
    data_in = VEC_IN;
    enable  = 1'b1;
    @(negedge clk);
    enable  = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1 checkOutput("abort_immediate", {busy, done, data_out}, 130'd0);
    @(negedge clk);
    reset   = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkOutput("abort_no_done", 130'(doneCnt), 130'd0);
    applyStimulus(VEC_IN, VEC_OUT, "after_abort");

    // Round trip through a MixColumns model.
    for (int n = 0; n < 1000; n++) begin
      x = rand128();
      applyStimulus(colXform(x, 1'b0), x, "roundtrip");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
